instruction_fetcher: RTL and testbench

Front-end fetch stage feeding the decoder. It issues one instruction-fetch request per cycle into the load/store buffer's fetch queue (`new_ins`/`pc_addr`) and collects in-order returned words (`ins_ready`/`ins_value`). It pairs each word with its PC, holds it in a small output queue, and presents it to decode under valid/ready. It honours redirects by discarding in-flight fetches that cannot be cancelled at the memory side.

---
 rtl/instruction_fetcher_pkg.sv | 16 +
 rtl/fetch_sync_fifo.sv | 71 +++++++
 rtl/instruction_fetcher.sv | 135 +++++++++++++
 tb/tb_instruction_fetcher.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetcher_pkg.sv
// Shared RV32 helpers for the front end: JAL opcode and J-type immediate
// extraction, also used by the decoder.
package instruction_fetcher_pkg;

   localparam logic [6:0] OPC_JAL = 7'b1101111;

   function automatic logic is_jal(input logic [31:0] ins);
      return ins[6:0] == OPC_JAL;
   endfunction

   // imm[20|10:1|11|19:12] sits in ins[31:12]; result is sign-extended, bit 0 clear
   function automatic logic [31:0] j_imm(input logic [31:0] ins);
      return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// Small synchronous FIFO with show-ahead head, flush and occupancy count.
// DEPTH need not be a power of two; pointers wrap explicitly.
module fetch_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Flush beats a same-cycle push: a word arriving with a flush is stale.
   assign do_push = push_i && !flush_i;
   assign do_pop  = pop_i && !flush_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: credit-limited in-order fetch issue, PC/word pairing, decode queue.
// Optional JAL predecode/redirect enabled by defining FETCH_JAL_PREDECODE_EN.
module instruction_fetcher
   import instruction_fetcher_pkg::*;
#(
   parameter int          QUEUE_DEPTH  = 4,
   parameter int          MAX_INFLIGHT = 6,
   parameter logic [31:0] RESET_PC     = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pause,
   input  logic        if_full,
   output logic        new_ins,
   output logic [31:0] pc_addr,
   input  logic        ins_ready,
   input  logic [31:0] ins_value,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_ins,
   output logic [31:0] out_pc,
   output logic        out_pred_taken
);

   localparam int IW = $clog2(MAX_INFLIGHT + 1);
   localparam int QW = $clog2(QUEUE_DEPTH + 1);
   localparam int SW = ((IW > QW) ? IW : QW) + 1;
`ifdef FETCH_JAL_PREDECODE_EN
   localparam int OQ_W = 65;
`else
   localparam int OQ_W = 64;
`endif

   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [IW-1:0]   discard_q, discard_d;
   logic [IW-1:0]   inflight, inflight_post;
   logic [QW-1:0]   oq_count;
   logic [31:0]     ret_pc;
   logic [OQ_W-1:0] oq_head, oq_push_data;
   logic            active, redir, ret, keep, jal_hit, room, issue, oq_pop;

   assign active = !pause && !rst;
   assign redir  = active && redirect;
   assign ret    = active && ins_ready;
   assign keep   = ret && (discard_q == '0) && !redirect;

`ifdef FETCH_JAL_PREDECODE_EN
   logic [31:0] jal_target;
   assign jal_hit        = keep && is_jal(ins_value);
   assign jal_target     = ret_pc + j_imm(ins_value);
   assign oq_push_data   = {jal_hit, ins_value, ret_pc};
   assign out_pred_taken = out_valid && oq_head[64];
`else
   assign jal_hit        = 1'b0;
   assign oq_push_data   = {ins_value, ret_pc};
   assign out_pred_taken = 1'b0;
`endif

   // Outstanding requests plus queued words never exceed the queue, so every return has a slot.
   assign room  = (inflight < IW'(MAX_INFLIGHT)) &&
                  ((SW'(inflight) + SW'(oq_count)) < SW'(QUEUE_DEPTH));
   assign issue = active && !redirect && !jal_hit && !if_full && room;
   assign inflight_post = inflight - IW'(ret);
   assign oq_pop = active && !redirect && out_valid && out_ready;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      if (ret && (discard_q != '0)) begin
         discard_d = discard_q - IW'(1);
      end
      if (issue) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      // After a redirect every request still outstanding is stale, already-marked ones included.
      if (redir) begin
         fetch_pc_d = redirect_pc;
         discard_d  = inflight_post;
      end
`ifdef FETCH_JAL_PREDECODE_EN
      else if (jal_hit) begin
         fetch_pc_d = jal_target;
         discard_d  = inflight_post;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         discard_q  <= discard_d;
      end
   end

   // The PC FIFO occupancy doubles as the in-flight counter.
   fetch_sync_fifo #(
      .WIDTH (32),
      .DEPTH (MAX_INFLIGHT)
   ) u_pc_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (issue),
      .push_data_i (fetch_pc_q),
      .pop_i       (ret),
      .flush_i     (1'b0),
      .head_o      (ret_pc),
      .count_o     (inflight)
   );

   fetch_sync_fifo #(
      .WIDTH (OQ_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_out_queue (
      .clk         (clk),
      .rst         (rst),
      .push_i      (keep),
      .push_data_i (oq_push_data),
      .pop_i       (oq_pop),
      .flush_i     (redir),
      .head_o      (oq_head),
      .count_o     (oq_count)
   );

   assign new_ins   = issue;
   assign pc_addr   = fetch_pc_q;
   assign out_valid = (oq_count != '0);
   assign out_ins   = out_valid ? oq_head[63:32] : 32'h0;
   assign out_pc    = out_valid ? oq_head[31:0]  : 32'h0;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: fixed-latency in-order memory model plus a
// scoreboard of expected {pc, word, pred} entries, phase table and corner sequences.
module tb_instruction_fetcher;

   localparam int          LAT    = 7;
   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pause = 1'b0;
   logic        if_full = 1'b0;
   logic        new_ins;
   logic [31:0] pc_addr;
   logic        ins_ready = 1'b0;
   logic [31:0] ins_value = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_ins;
   logic [31:0] out_pc;
   logic        out_pred_taken;

   always #5 clk = ~clk;

   instruction_fetcher #(
      .QUEUE_DEPTH  (4),
      .MAX_INFLIGHT (6),
      .RESET_PC     (RST_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pause          (pause),
      .if_full        (if_full),
      .new_ins        (new_ins),
      .pc_addr        (pc_addr),
      .ins_ready      (ins_ready),
      .ins_value      (ins_value),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_ins        (out_ins),
      .out_pc         (out_pc),
      .out_pred_taken (out_pred_taken)
   );

   typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] ins; bit pred; } exp_t;
   typedef struct { int ncyc; bit rdy; bit full; int exp_pulses; int exp_xfers; } phase_t;

   req_t        pend[$];
   exp_t        expq[$];
   int          nret = 0;
   logic [31:0] exp_pc = RST_PC;
   int          cyc = 0;
   int          pulses = 0;
   int          xfers = 0;
   int          stale_rets = 0;
   int          first_valid = -1;
   int          jal_seen = 0;
   bit          jal_word_en = 1'b0;
   bit          want_first = 1'b0;
   logic [31:0] first_pc_after = 32'hFFFF_FFFF;
   logic [31:0] prev_pc = 32'hFFFF_FFFF;
   logic [31:0] after_jal_pc = 32'hFFFF_FFFF;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (jal_word_en && a == 32'h10) return 32'h0080_006F;
      return {a[24:0], 7'b0010011};
   endfunction

   function automatic logic [31:0] tb_jimm(input logic [31:0] w);
      return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
   endfunction

   task automatic mark_all_stale();
      req_t r;
      for (int i = 0; i < pend.size(); i++) begin
         r = pend[i];
         r.stale = 1'b1;
         pend[i] = r;
      end
   endtask

   // First half of a cycle: memory drives its return, outputs settle.
   task automatic tick_pre();
      @(negedge clk);
      if (!rst && !pause && pend.size() > 0 && pend[0].due <= cyc) begin
         ins_ready = 1'b1;
         ins_value = mem_word(pend[0].addr);
      end else begin
         ins_ready = 1'b0;
         ins_value = 32'h0;
      end
      #1;
   endtask

   // Second half: scoreboard/model update from sampled outputs, then clock edge.
   task automatic tick_post();
      exp_t e;
      req_t r;
      if (rst) begin
         pend.delete();
         expq.delete();
         nret = 0;
         exp_pc = RST_PC;
      end else if (!pause) begin
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && out_ready && !redirect) begin
            xfers++;
            if (nret == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL xfer_unexpected: got output pc 0x%08h, expected no output", out_pc);
            end else begin
               e = expq.pop_front();
               nret--;
               check("out_pc", out_pc, e.pc);
               check("out_ins", out_ins, e.ins);
               check("out_pred_taken", 32'(out_pred_taken), 32'(e.pred));
               if (want_first) begin
                  first_pc_after = out_pc;
                  want_first = 1'b0;
               end
               if (prev_pc == 32'h10) after_jal_pc = out_pc;
               prev_pc = out_pc;
            end
         end
         if (ins_ready) begin
            r = pend.pop_front();
            if (r.stale) begin
               stale_rets++;
            end else if (nret < expq.size()) begin
`ifdef FETCH_JAL_PREDECODE_EN
               if (ins_value[6:0] == 7'b1101111 && !redirect) begin
                  e = expq[nret];
                  e.pred = 1'b1;
                  expq[nret] = e;
                  while (expq.size() > nret + 1) void'(expq.pop_back());
                  mark_all_stale();
                  exp_pc = e.pc + tb_jimm(ins_value);
                  check("jal_cycle_new_ins", 32'(new_ins), 32'h0);
                  jal_seen++;
               end
`endif
               nret++;
            end
         end
         if (redirect) begin
            check("redirect_cycle_new_ins", 32'(new_ins), 32'h0);
            expq.delete();
            nret = 0;
            mark_all_stale();
            exp_pc = redirect_pc;
         end
         if (new_ins) begin
            pulses++;
            check("pc_addr", pc_addr, exp_pc);
            r.addr = exp_pc;
            r.due = cyc + LAT;
            r.stale = 1'b0;
            pend.push_back(r);
            e.pc = exp_pc;
            e.ins = mem_word(exp_pc);
            e.pred = 1'b0;
            expq.push_back(e);
            exp_pc = exp_pc + 32'd4;
         end
         cyc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      tick_pre();
      tick_post();
   endtask

   task automatic do_reset(input bit check_state);
      rst = 1'b1;
      pause = 1'b0;
      redirect = 1'b0;
      if_full = 1'b0;
      out_ready = 1'b0;
      tick();
      tick_pre();
      if (check_state) begin
         check("rst_new_ins", 32'(new_ins), 32'h0);
         check("rst_pc_addr", pc_addr, RST_PC);
         check("rst_out_valid", 32'(out_valid), 32'h0);
         check("rst_out_ins", out_ins, 32'h0);
         check("rst_out_pc", out_pc, 32'h0);
         check("rst_out_pred_taken", 32'(out_pred_taken), 32'h0);
      end
      tick_post();
      rst = 1'b0;
      cyc = 0;
      first_valid = -1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by time limit, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      phase_t tbl[6];
      int p0;
      int x0;
      tbl[0] = '{2,  1'b1, 1'b0, 2, 0};
      tbl[1] = '{5,  1'b1, 1'b1, 0, 0};
      tbl[2] = '{20, 1'b0, 1'b0, 2, 0};
      tbl[3] = '{10, 1'b1, 1'b1, 0, 4};
      tbl[4] = '{9,  1'b1, 1'b0, 4, 1};
      tbl[5] = '{12, 1'b1, 1'b1, 0, 3};

      do_reset(1'b1);

      // Phase table: flow control, if_full window, credit stop with out_ready low
      for (int p = 0; p < 6; p++) begin
         out_ready = tbl[p].rdy;
         if_full = tbl[p].full;
         p0 = pulses;
         x0 = xfers;
         repeat (tbl[p].ncyc) tick();
         check($sformatf("phase%0d_new_ins_pulses", p), 32'(pulses - p0), 32'(tbl[p].exp_pulses));
         check($sformatf("phase%0d_transfers", p), 32'(xfers - x0), 32'(tbl[p].exp_xfers));
      end
      check("first_out_valid_cycle", 32'(first_valid), 32'd8);
      check("table_drained", 32'(expq.size() + pend.size()), 32'h0);

      // Redirect with three requests outstanding
      do_reset(1'b0);
      out_ready = 1'b1;
      repeat (3) tick();
      stale_rets = 0;
      redirect = 1'b1;
      redirect_pc = 32'h100;
      tick_pre();
      check("redir_new_ins_low", 32'(new_ins), 32'h0);
      tick_post();
      redirect = 1'b0;
      want_first = 1'b1;
      tick_pre();
      check("redir_next_new_ins", 32'(new_ins), 32'h1);
      check("redir_next_pc_addr", pc_addr, 32'h100);
      tick_post();
      repeat (30) tick();
      check("redir_dropped_returns", 32'(stale_rets), 32'd3);
      check("redir_first_out_pc", first_pc_after, 32'h100);

      // Pause holds everything, then reset mid-operation
      do_reset(1'b0);
      repeat (10) tick();
      out_ready = 1'b1;
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick_pre();
         check("pause_new_ins", 32'(new_ins), 32'h0);
         check("pause_out_valid", 32'(out_valid), 32'h1);
         check("pause_out_pc", out_pc, RST_PC);
         check("pause_out_ins", out_ins, mem_word(RST_PC));
         tick_post();
      end
      pause = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick_pre();
      check("post_rst_out_valid", 32'(out_valid), 32'h0);
      check("post_rst_new_ins", 32'(new_ins), 32'h1);
      check("post_rst_pc_addr", pc_addr, RST_PC);
      tick_post();
      if_full = 1'b0;
      repeat (12) tick();
      if_full = 1'b1;
      repeat (20) tick();
      check("post_rst_drained", 32'(expq.size() + pend.size()), 32'h0);

`ifdef FETCH_JAL_PREDECODE_EN
      // JAL at 0x10 with +8 offset: younger fetches dropped, fetch resumes at 0x18
      do_reset(1'b0);
      jal_word_en = 1'b1;
      out_ready = 1'b1;
      jal_seen = 0;
      prev_pc = 32'hFFFF_FFFF;
      after_jal_pc = 32'hFFFF_FFFF;
      repeat (50) tick();
      check("jal_predicted", 32'(jal_seen), 32'd1);
      check("jal_next_out_pc", after_jal_pc, 32'h18);
      jal_word_en = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
